// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the fetch/PC sequencer: default datapath width, reset PC
// and the sequencer state encoding.
package pc_fetch_sequencer_pkg;

    localparam int              WIDTH    = 16;
    localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_ACK = 2'd1,
        EXEC     = 2'd2,
        HALTED   = 2'd3
    } state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: halt > jump > branch taken > sequential.
// Also exports the sequential PC so the top can publish pc + INCR.
module pc_next_mux #(
    parameter int WIDTH = 16,
    parameter int INCR  = 1
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic             halt_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    output logic [WIDTH-1:0] pc_seq_o,
    output logic [WIDTH-1:0] pc_next_o
);

    // Wraps mod 2^WIDTH by construction of the adder width.
    assign pc_seq_o = pc_i + WIDTH'(INCR);

    always_comb begin
        pc_next_o = pc_seq_o;
        if (halt_i)              pc_next_o = pc_i;
        else if (jump_i)         pc_next_o = jump_target_i;
        else if (branch_taken_i) pc_next_o = branch_target_i;
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multicycle fetch controller: owns PC and IR, runs the instruction-memory
// handshake and waits for the control unit to retire each instruction.
module pc_fetch_sequencer #(
    parameter int                                      WIDTH    = pc_fetch_sequencer_pkg::WIDTH,
    parameter logic [pc_fetch_sequencer_pkg::WIDTH-1:0] RESET_PC = pc_fetch_sequencer_pkg::RESET_PC,
    parameter int                                      INCR     = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] ir,
    output logic             ir_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    input  logic             ctrl_done,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             halt,
    output logic             halted
);

    import pc_fetch_sequencer_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic             ir_valid_q, ir_valid_d;
    logic             req_q, req_d;
    logic             halted_q, halted_d;
    logic [WIDTH-1:0] pc_seq, pc_next;

    pc_next_mux #(
        .WIDTH (WIDTH),
        .INCR  (INCR)
    ) u_next_mux (
        .pc_i            (pc_q),
        .halt_i          (halt),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .pc_seq_o        (pc_seq),
        .pc_next_o       (pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= WIDTH'(RESET_PC);
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            req_q      <= req_d;
            halted_q   <= halted_d;
        end
    end

    // The request is registered so imem_ack never has a combinational path back to imem_req.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        req_d      = req_q;
        halted_d   = halted_q;
        case (state_q)
            FETCH: begin
                req_d   = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    ir_valid_d = 1'b1;
                    req_d      = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (ctrl_done) begin
                    ir_valid_d = 1'b0;
                    pc_d       = pc_next;
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        state_d  = FETCH;
                    end
                end
            end
            HALTED: begin
                req_d = 1'b0;
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign pc        = pc_q;
    assign pc_plus1  = pc_seq;
    assign halted    = halted_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: the driver predicts fetch addresses and
// instruction words into queues, a negedge monitor pops and compares them.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        ctrl_done;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic [15:0] jump_target;
    logic        halt;
    logic        halted;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_ir_q[$];
    logic [15:0] last_addr = 16'h0000;
    logic        prev_ir_valid = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .ctrl_done     (ctrl_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .halted        (halted)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        ctrl_done     = 1'b0;
        jump          = 1'b0;
        branch_taken  = 1'b0;
        halt          = 1'b0;
    endtask

    // Monitor: every accepted fetch and every newly latched instruction is checked.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (imem_req && imem_ack) begin
                    if (exp_addr_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
                    end else begin
                        last_addr = exp_addr_q.pop_front();
                        chk("fetch_addr", imem_addr, last_addr);
                    end
                end
                if (ir_valid && !prev_ir_valid) begin
                    if (exp_ir_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL ir_unexpected: got ir %h expected none", ir);
                    end else begin
                        chk("ir_word", ir, exp_ir_q.pop_front());
                        chk("pc_of_ir", pc, last_addr);
                        chk("pc_plus1", pc_plus1, last_addr + 16'd1);
                    end
                end
            end
            prev_ir_valid = ir_valid;
        end
    end

    task automatic do_fetch(input int delay, input logic [15:0] data);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: got imem_req 0 expected 1 within 20 cycles");
            return;
        end
        // Stray control-unit pulses while waiting for memory must be ignored.
        for (int i = 0; i < delay; i++) begin
            ctrl_done   = 1'($urandom_range(0, 1));
            jump        = 1'b1;
            jump_target = 16'($urandom);
            tick();
            clear_ctrl();
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_ir_q.push_back(data);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
    endtask

    task automatic do_exec(input int wait_c, input logic h, input logic j, input logic [15:0] jt,
                           input logic b, input logic [15:0] bt);
        logic [15:0] nxt;
        for (int i = 0; i < wait_c; i++) begin
            jump          = 1'($urandom_range(0, 1));
            jump_target   = 16'($urandom);
            branch_taken  = 1'($urandom_range(0, 1));
            halt          = 1'($urandom_range(0, 1));
            tick();
            clear_ctrl();
        end
        ctrl_done     = 1'b1;
        halt          = h;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        if (!h) begin
            if (j)      nxt = jt;
            else if (b) nxt = bt;
            else        nxt = last_addr + 16'd1;
            exp_addr_q.push_back(nxt);
        end
        tick();
        clear_ctrl();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] r16a, r16b;
        int          sel;
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 16'h0000;
        branch_target = 16'h0000;
        jump_target = 16'h0000;
        clear_ctrl();
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        exp_addr_q.push_back(16'h0000);

        // First instruction, ack one cycle after req.
        do_fetch(1, 16'h1234);
        tick();
        chk("exec_ir_hold", ir, 16'h1234);

        // Three sequential retirements.
        for (int i = 0; i < 3; i++) begin
            do_exec(1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
            do_fetch(0, 16'(16'h2000 + i));
        end

        // Jump outranks a simultaneous taken branch.
        do_exec(0, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0080);
        do_fetch(0, 16'hA5A5);

        // PC wrap at the top of the address space.
        do_exec(0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0);
        do_fetch(2, 16'h7777);
        do_exec(1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        do_fetch(0, 16'h8888);

        for (int k = 0; k < 40; k++) begin
            sel  = $urandom_range(0, 3);
            r16a = 16'($urandom);
            r16b = 16'($urandom);
            do_exec($urandom_range(0, 3), 1'b0, sel == 2, r16a,
                    (sel == 3) || (sel == 2 && r16b[0]), r16b);
            do_fetch($urandom_range(0, 3), 16'($urandom));
        end

        // Reset while waiting for memory, with an ack in the same cycle.
        do_exec(0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        begin
            int n = 0;
            while (!imem_req && n < 20) begin
                tick();
                n++;
            end
        end
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        reset    = 1'b0;
        imem_ack = 1'b0;
        chk("rstwait_req", {15'd0, imem_req}, 16'd0);
        chk("rstwait_ir_valid", {15'd0, ir_valid}, 16'd0);
        chk("rstwait_pc", pc, 16'h0000);
        chk("rstwait_ir", ir, 16'h0000);
        exp_addr_q.delete();
        exp_addr_q.push_back(16'h0000);

        do_fetch(0, 16'h5555);
        do_exec(2, 1'b1, 1'b1, 16'h1111, 1'b1, 16'h2222);
        chk("halt_halted", {15'd0, halted}, 16'd1);
        chk("halt_ir_valid", {15'd0, ir_valid}, 16'd0);
        chk("halt_pc", pc, last_addr);
        for (int i = 0; i < 20; i++) begin
            ctrl_done   = 1'($urandom_range(0, 1));
            jump        = 1'($urandom_range(0, 1));
            jump_target = 16'($urandom);
            imem_ack    = 1'($urandom_range(0, 1));
            tick();
            chk("halted_no_req", {15'd0, imem_req}, 16'd0);
        end
        clear_ctrl();
        imem_ack = 1'b0;
        chk("halted_stays", {15'd0, halted}, 16'd1);
        chk("halted_pc_hold", pc, last_addr);
        chk("addr_q_drained", 16'(exp_addr_q.size()), 16'd0);
        chk("ir_q_drained", 16'(exp_ir_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
